// File: rtl/tmr_voter_pipe.sv
// Registered TMR voter: bitwise majority of three replica words with error reporting and mode degradation.
// Latency: 1 cycle from valid_i to valid_o; all status outputs update alongside the causing beat.
// Backpressure: none; a beat is accepted every cycle valid_i is high.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i, data_i      replica beat; data_i[r] is replica r
//   clear_i              synchronous clear of faulty flags, streaks, error counter and mode
//   valid_o, data_o      voted word (data_o holds while idle)
//   err_corr_o           single-replica disagreement masked on this beat
//   err_uncorr_o         disagreement that could not be masked on this beat
//   faulty_o             sticky per-replica faulty flags
//   mode_o               00 TMR, 01 DMR, 10 FAIL
//   err_cnt_o            saturating count of errored beats
module tmr_voter_pipe #(
  parameter int WIDTH      = 32,
  parameter int PERSIST_TH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [2:0][WIDTH-1:0]  data_i,
  input  logic                   clear_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   err_corr_o,
  output logic                   err_uncorr_o,
  output logic [2:0]             faulty_o,
  output logic [1:0]             mode_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  // Streak counters only need to reach PERSIST_TH before the replica is retired.
  localparam int SW = $clog2(PERSIST_TH + 1);

  typedef enum logic [1:0] {
    MODE_TMR  = 2'b00,
    MODE_DMR  = 2'b01,
    MODE_FAIL = 2'b10
  } mode_e;

  mode_e                 mode_q, mode_d, mode_cur;
  logic [2:0]            faulty_d, faulty_cur;
  logic [2:0][SW-1:0]    streak_q, streak_d, streak_cur;
  logic [ERR_CNT_W-1:0]  cnt_d, cnt_cur;
  logic [WIDTH-1:0]      maj, vote;
  logic                  eq01, eq02, eq12;
  logic                  corr, uncorr;
  logic [1:0]            bad, h0, h1;
  logic [SW-1:0]         bump;

  assign maj  = (data_i[0] & data_i[1]) | (data_i[0] & data_i[2]) | (data_i[1] & data_i[2]);
  assign eq01 = (data_i[0] == data_i[1]);
  assign eq02 = (data_i[0] == data_i[2]);
  assign eq12 = (data_i[1] == data_i[2]);

  // A clear in the same cycle as a beat makes the beat see fully reset state.
  assign mode_cur   = clear_i ? MODE_TMR : mode_q;
  assign faulty_cur = clear_i ? 3'b000   : faulty_o;
  assign streak_cur = clear_i ? '0       : streak_q;
  assign cnt_cur    = clear_i ? '0       : err_cnt_o;

  always_comb begin
    mode_d   = mode_cur;
    faulty_d = faulty_cur;
    streak_d = streak_cur;
    vote     = maj;
    corr     = 1'b0;
    uncorr   = 1'b0;
    bad      = 2'd0;
    bump     = '0;
    h0       = 2'd0;
    h1       = 2'd1;
    if (valid_i) begin
      unique case (mode_cur)
        MODE_TMR: begin
          if (eq01 && eq12) begin
            streak_d = '0;
          end else if (!eq01 && !eq02 && !eq12) begin
            // Streaks are held: no replica can be singled out.
            uncorr = 1'b1;
            mode_d = MODE_FAIL;
          end else begin
            corr     = 1'b1;
            bad      = eq12 ? 2'd0 : (eq02 ? 2'd1 : 2'd2);
            bump     = streak_cur[bad] + 1'b1;
            streak_d = '0;
            streak_d[bad] = bump;
            if (bump >= SW'(PERSIST_TH)) begin
              faulty_d[bad] = 1'b1;
              mode_d        = MODE_DMR;
            end
          end
        end
        MODE_DMR: begin
          // Exactly one faulty bit is set here; pick the two survivors in index order.
          if (faulty_cur[0]) begin
            h0 = 2'd1;
            h1 = 2'd2;
          end else if (faulty_cur[1]) begin
            h0 = 2'd0;
            h1 = 2'd2;
          end
          vote = data_i[h0];
          if (data_i[h0] != data_i[h1]) begin
            uncorr = 1'b1;
            mode_d = MODE_FAIL;
          end
        end
        default: begin
          uncorr = 1'b1;
          mode_d = MODE_FAIL;
        end
      endcase
    end
    cnt_d = cnt_cur;
    if (valid_i && (corr || uncorr) && (cnt_cur != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_cur + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q       <= MODE_TMR;
      faulty_o     <= 3'b000;
      streak_q     <= '0;
      err_cnt_o    <= '0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      err_corr_o   <= 1'b0;
      err_uncorr_o <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      faulty_o     <= faulty_d;
      streak_q     <= streak_d;
      err_cnt_o    <= cnt_d;
      valid_o      <= valid_i;
      err_corr_o   <= corr;
      err_uncorr_o <= uncorr;
      if (valid_i) begin
        data_o <= vote;
      end
    end
  end

  assign mode_o = mode_q;

endmodule

// File: tb/tb_tmr_voter_pipe.sv
// Bench for tmr_voter_pipe: table of beats with hand-derived expectations, scoreboard queue,
// plus a second instance with a 2-bit error counter for saturation and an async reset check.
module tb_tmr_voter_pipe;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid;
  logic            clear;
  logic [2:0][7:0] data;

  logic       vo_a, corr_a, unc_a;
  logic [7:0] do_a;
  logic [2:0] flt_a;
  logic [1:0] md_a;
  logic [7:0] cnt_a;

  logic       vo_b, corr_b, unc_b;
  logic [7:0] do_b;
  logic [2:0] flt_b;
  logic [1:0] md_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  tmr_voter_pipe #(.WIDTH(8), .PERSIST_TH(4), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_i(clear),
    .valid_o(vo_a), .data_o(do_a), .err_corr_o(corr_a), .err_uncorr_o(unc_a),
    .faulty_o(flt_a), .mode_o(md_a), .err_cnt_o(cnt_a)
  );

  tmr_voter_pipe #(.WIDTH(8), .PERSIST_TH(4), .ERR_CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_i(clear),
    .valid_o(vo_b), .data_o(do_b), .err_corr_o(corr_b), .err_uncorr_o(unc_b),
    .faulty_o(flt_b), .mode_o(md_b), .err_cnt_o(cnt_b)
  );

  typedef struct {
    logic       v;
    logic       clr;
    logic [7:0] d2, d1, d0;
    logic [7:0] ed;
    logic       ec, eu;
    logic [2:0] ef;
    logic [1:0] em;
    logic [7:0] ecnt;
  } vec_t;

  typedef struct {
    vec_t x;
    int   due;
    int   idx;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  function automatic vec_t mk(logic v, logic clr, logic [7:0] d2, logic [7:0] d1, logic [7:0] d0,
                              logic [7:0] ed, logic ec, logic eu, logic [2:0] ef, logic [1:0] em,
                              logic [7:0] ecnt);
    vec_t r;
    r.v = v; r.clr = clr; r.d2 = d2; r.d1 = d1; r.d0 = d0;
    r.ed = ed; r.ec = ec; r.eu = eu; r.ef = ef; r.em = em; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic drive(input vec_t x, input int idx);
    sb_t s;
    @(negedge clk);
    valid = x.v;
    clear = x.clr;
    data  = {x.d2, x.d1, x.d0};
    s.x   = x;
    s.due = cyc + 1;
    s.idx = idx;
    sbq.push_back(s);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({vo_a, do_a, corr_a, unc_a, flt_a, md_a, cnt_a} !== '0 ||
        {vo_b, do_b, corr_b, unc_b, flt_b, md_b, cnt_b} !== '0) begin
      n_bad++;
      $display("FAIL %s: got a=%b/%h/%b%b/%b/%b/%0d b=%b/%h/%b%b/%b/%b/%0d, need all zero", name,
               vo_a, do_a, corr_a, unc_a, flt_a, md_a, cnt_a,
               vo_b, do_b, corr_b, unc_b, flt_b, md_b, cnt_b);
    end
  endtask

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if ({vo_a, do_a, corr_a, unc_a, flt_a, md_a, cnt_a} !==
            {e.x.v, e.x.ed, e.x.ec, e.x.eu, e.x.ef, e.x.em, e.x.ecnt}) begin
          n_bad++;
          $display("FAIL beat%0d: got v=%b d=%h c=%b u=%b f=%b m=%b n=%0d, need v=%b d=%h c=%b u=%b f=%b m=%b n=%0d",
                   e.idx, vo_a, do_a, corr_a, unc_a, flt_a, md_a, cnt_a,
                   e.x.v, e.x.ed, e.x.ec, e.x.eu, e.x.ef, e.x.em, e.x.ecnt);
        end
      end else begin
        n_cmp++;
        if (vo_a !== 1'b0 || corr_a !== 1'b0 || unc_a !== 1'b0) begin
          n_bad++;
          $display("FAIL spurious_out cyc%0d: got v=%b c=%b u=%b, need 0 0 0", cyc, vo_a, corr_a, unc_a);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    data  = '0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    //            v  clr d2     d1     d0     data   c  u  faulty  mode   cnt
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h25, 8'h25, 0, 0, 3'b000, 2'b00, 8'd0));
    tbl.push_back(mk(1, 0, 8'h21, 8'h25, 8'h25, 8'h25, 1, 0, 3'b000, 2'b00, 8'd1));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h25, 8'h25, 0, 0, 3'b000, 2'b00, 8'd1));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd2));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd3));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd4));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h25, 8'h25, 0, 0, 3'b000, 2'b00, 8'd4));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd5));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd6));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd7));
    // idle cycle: state and data_o hold, streak of replica 0 stays at 3
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h25, 0, 0, 3'b000, 2'b00, 8'd7));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b001, 2'b01, 8'd8));
    // DMR on replicas 1,2
    tbl.push_back(mk(1, 0, 8'h33, 8'h33, 8'h00, 8'h33, 0, 0, 3'b001, 2'b01, 8'd8));
    tbl.push_back(mk(1, 0, 8'h45, 8'h44, 8'hFF, 8'h44, 0, 1, 3'b001, 2'b10, 8'd9));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h25, 8'h25, 0, 1, 3'b001, 2'b10, 8'd10));
    tbl.push_back(mk(1, 1, 8'h33, 8'h33, 8'h33, 8'h33, 0, 0, 3'b000, 2'b00, 8'd0));
    // no two equal in TMR
    tbl.push_back(mk(1, 0, 8'h04, 8'h02, 8'h01, 8'h00, 0, 1, 3'b000, 2'b10, 8'd1));
    tbl.push_back(mk(1, 0, 8'h04, 8'h02, 8'h01, 8'h00, 0, 1, 3'b000, 2'b10, 8'd2));
    tbl.push_back(mk(1, 1, 8'h33, 8'h33, 8'h33, 8'h33, 0, 0, 3'b000, 2'b00, 8'd0));
    tbl.push_back(mk(1, 1, 8'h33, 8'h31, 8'h33, 8'h33, 1, 0, 3'b000, 2'b00, 8'd1));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h33, 0, 0, 3'b000, 2'b00, 8'd0));
    // replica 2 retired, DMR on replicas 0,1
    tbl.push_back(mk(1, 0, 8'h3A, 8'h55, 8'h55, 8'h55, 1, 0, 3'b000, 2'b00, 8'd1));
    tbl.push_back(mk(1, 0, 8'h3A, 8'h55, 8'h55, 8'h55, 1, 0, 3'b000, 2'b00, 8'd2));
    tbl.push_back(mk(1, 0, 8'h3A, 8'h55, 8'h55, 8'h55, 1, 0, 3'b000, 2'b00, 8'd3));
    tbl.push_back(mk(1, 0, 8'h3A, 8'h55, 8'h55, 8'h55, 1, 0, 3'b100, 2'b01, 8'd4));
    tbl.push_back(mk(1, 0, 8'h00, 8'h55, 8'h55, 8'h55, 0, 0, 3'b100, 2'b01, 8'd4));
    tbl.push_back(mk(1, 0, 8'h00, 8'hAA, 8'h0F, 8'h0F, 0, 1, 3'b100, 2'b10, 8'd5));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 8'h00, 8'h0F, 0, 0, 3'b000, 2'b00, 8'd0));
    // five corrected beats spread over replicas so none gets retired
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd1));
    tbl.push_back(mk(1, 0, 8'h25, 8'h24, 8'h25, 8'h25, 1, 0, 3'b000, 2'b00, 8'd2));
    tbl.push_back(mk(1, 0, 8'h24, 8'h25, 8'h25, 8'h25, 1, 0, 3'b000, 2'b00, 8'd3));
    tbl.push_back(mk(1, 0, 8'h25, 8'h25, 8'h24, 8'h25, 1, 0, 3'b000, 2'b00, 8'd4));
    tbl.push_back(mk(1, 0, 8'h25, 8'h24, 8'h25, 8'h25, 1, 0, 3'b000, 2'b00, 8'd5));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], i);
    end

    // last beat's output is now valid; the 2-bit counter must have saturated at 3
    @(posedge clk);
    #2;
    n_cmp++;
    if (cnt_b !== 2'd3) begin
      n_bad++;
      $display("FAIL cnt_saturate: got %0d, need 3", cnt_b);
    end

    // asynchronous reset while an output beat is still presented
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL missing_outputs: got %0d pending, need 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
